// File: rtl/emergency_preempt_ctrl.sv
// Emergency-vehicle pre-emption conditioner: synchronizes and debounces the NS/EW
// detectors, then drives one registered emergency level with min/max hold and cooldown.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | no request seen; waiting for either synchronized detector
// ST_ARM      | debouncing the latched direction's request
// ST_PREEMPT  | emergency asserted; hold counter runs up to HOLD_MAX
// ST_COOLDOWN | emergency released; all requests ignored for COOLDOWN cycles
module emergency_preempt_ctrl #(
    parameter int DEBOUNCE = 4,
    parameter int HOLD_MIN = 16,
    parameter int HOLD_MAX = 255,
    parameter int COOLDOWN = 8,
    parameter int COUNT_W  = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req_ns,
    input  logic               req_ew,
    output logic               emergency,
    output logic               dir_ew,
    output logic               busy,
    output logic               fault,
    output logic [COUNT_W-1:0] preempt_count
);

    localparam int CNT_W  = $clog2(DEBOUNCE + 1);
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);
    localparam int CD_W   = $clog2(COOLDOWN + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARM      = 2'd1,
        ST_PREEMPT  = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_ns_meta;
    logic               r_ns_sync;
    logic               r_ew_meta;
    logic               r_ew_sync;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [HOLD_W-1:0]  r_hold;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic [CD_W-1:0]    r_cd;
    logic [CD_W-1:0]    w_cd_nxt;
    logic               r_dir_ew;
    logic               w_dir_nxt;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_count_nxt;
    logic               r_fault;
    logic               w_fault_nxt;
    logic               r_emergency;
    logic               r_busy;
    logic               w_req_sel;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ns_meta <= 1'b0;
            r_ns_sync <= 1'b0;
            r_ew_meta <= 1'b0;
            r_ew_sync <= 1'b0;
        end else begin
            r_ns_meta <= req_ns;
            r_ns_sync <= r_ns_meta;
            r_ew_meta <= req_ew;
            r_ew_sync <= r_ew_meta;
        end
    end

    // Once a direction is latched only that detector can keep the sequence alive.
    assign w_req_sel = r_dir_ew ? r_ew_sync : r_ns_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_cd        <= '0;
            r_dir_ew    <= 1'b0;
            r_count     <= '0;
            r_fault     <= 1'b0;
            r_emergency <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hold      <= w_hold_nxt;
            r_cd        <= w_cd_nxt;
            r_dir_ew    <= w_dir_nxt;
            r_count     <= w_count_nxt;
            r_fault     <= w_fault_nxt;
            r_emergency <= (w_state_nxt == ST_PREEMPT);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = r_hold;
        w_cd_nxt    = r_cd;
        w_dir_nxt   = r_dir_ew;
        w_count_nxt = r_count;
        w_fault_nxt = r_fault;
        case (r_state)
            ST_IDLE: begin
                if (r_ns_sync || r_ew_sync) begin
                    w_state_nxt = ST_ARM;
                    w_cnt_nxt   = CNT_W'(1);
                    w_dir_nxt   = !r_ns_sync && r_ew_sync;
                end
            end
            ST_ARM: begin
                if (!w_req_sel) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_W'(DEBOUNCE)) begin
                    w_state_nxt = ST_PREEMPT;
                    w_hold_nxt  = HOLD_W'(1);
                    if (r_count != '1) begin
                        w_count_nxt = r_count + COUNT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_PREEMPT: begin
                // The stuck-sensor timeout wins over a normal release on the same edge.
                if (r_hold == HOLD_W'(HOLD_MAX)) begin
                    w_state_nxt = ST_COOLDOWN;
                    w_fault_nxt = 1'b1;
                    w_cd_nxt    = CD_W'(COOLDOWN - 1);
                end else if ((r_hold >= HOLD_W'(HOLD_MIN)) && !w_req_sel) begin
                    w_state_nxt = ST_COOLDOWN;
                    w_cd_nxt    = CD_W'(COOLDOWN - 1);
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            ST_COOLDOWN: begin
                if (r_cd == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cd_nxt = r_cd - CD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign emergency     = r_emergency;
    assign busy          = r_busy;
    assign dir_ew        = r_dir_ew;
    assign fault         = r_fault;
    assign preempt_count = r_count;

endmodule

// File: tb/tb_emergency_preempt_ctrl.sv
// Bench for emergency_preempt_ctrl: directed request patterns push expected pulse
// descriptions; a forked monitor measures each emergency pulse and compares.
module tb_emergency_preempt_ctrl;

    localparam int COOLDOWN = 8;

    logic       clock;
    logic       reset_n;
    logic       req_ns;
    logic       req_ew;
    logic       emergency;
    logic       dir_ew;
    logic       busy;
    logic       fault;
    logic [7:0] preempt_count;
    logic       s_emergency;
    logic       s_dir_ew;
    logic       s_busy;
    logic       s_fault;
    logic [1:0] s_count;

    emergency_preempt_ctrl u_dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_ns        (req_ns),
        .req_ew        (req_ew),
        .emergency     (emergency),
        .dir_ew        (dir_ew),
        .busy          (busy),
        .fault         (fault),
        .preempt_count (preempt_count)
    );

    emergency_preempt_ctrl #(.COUNT_W(2)) u_sat (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_ns        (req_ns),
        .req_ew        (req_ew),
        .emergency     (s_emergency),
        .dir_ew        (s_dir_ew),
        .busy          (s_busy),
        .fault         (s_fault),
        .preempt_count (s_count)
    );

    typedef struct {
        int rise;
        int width;
        bit dir;
        int cnt;
        int sat;
        bit flt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic monitor();
        logic prev_e = 1'b0;
        logic prev_b = 1'b0;
        bit   in_pulse = 1'b0;
        bit   fall_pend = 1'b0;
        int   rise = 0;
        int   fall = 0;
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (!reset_n) begin
                in_pulse  = 1'b0;
                fall_pend = 1'b0;
                prev_e    = 1'b0;
                prev_b    = 1'b0;
                continue;
            end
            if (emergency && !prev_e) begin
                rise     = cyc;
                in_pulse = 1'b1;
            end
            if (!emergency && prev_e && in_pulse) begin
                in_pulse  = 1'b0;
                fall      = cyc;
                fall_pend = 1'b1;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got pulse rising at %0d, expected none", rise);
                end else begin
                    e = exp_q.pop_front();
                    check("rise_cycle", rise, e.rise);
                    check("pulse_width", fall - rise, e.width);
                    check("dir_ew", dir_ew, e.dir);
                    check("preempt_count", preempt_count, e.cnt);
                    check("sat_count", s_count, e.sat);
                    check("fault", fault, e.flt);
                end
            end
            if (!busy && prev_b && fall_pend) begin
                fall_pend = 1'b0;
                check("cooldown_len", cyc - fall, COOLDOWN);
            end
            prev_e = emergency;
            prev_b = busy;
        end
    endtask

    task automatic wait_idle();
        int b = 0;
        while ((busy || emergency) && b < 600) begin
            @(negedge clock);
            b++;
        end
        if (b >= 600) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: got busy after %0d cycles, expected idle", b);
        end
        repeat (4) @(negedge clock);
    endtask

    function automatic void push(input int rise, input int width, input bit dir, input int cnt, input bit flt);
        exp_t e;
        e.rise  = rise;
        e.width = width;
        e.dir   = dir;
        e.cnt   = cnt;
        e.sat   = (cnt > 3) ? 3 : cnt;
        e.flt   = flt;
        exp_q.push_back(e);
    endfunction

    // Drive ns/ew high for ncyc sampled edges starting at edge 0.
    task automatic pulse(input bit ns, input bit ew, input int ncyc, input int width,
                         input bit dir, input int cnt, input bit flt);
        int e0;
        @(negedge clock);
        e0     = cyc + 1;
        req_ns = ns;
        req_ew = ew;
        push(e0 + 6, width, dir, cnt, flt);
        repeat (ncyc) @(negedge clock);
        req_ns = 1'b0;
        req_ew = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int  e0;
        int  b;
        bit  seen_b;
        bit  seen_e;
        reset_n = 1'b1;
        req_ns  = 1'b0;
        req_ew  = 1'b0;
        fork
            monitor();
        join_none
        #2 reset_n = 1'b0;
        #1;
        check("rst_emergency", emergency, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_dir", dir_ew, 0);
        check("rst_count", preempt_count, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // Glitch shorter than the debounce window.
        seen_b = 1'b0;
        seen_e = 1'b0;
        req_ns = 1'b1;
        repeat (3) @(negedge clock);
        req_ns = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (busy) seen_b = 1'b1;
            if (emergency) seen_e = 1'b1;
        end
        check("glitch_busy_seen", seen_b, 1);
        check("glitch_no_emergency", seen_e, 0);
        check("glitch_count", preempt_count, 0);
        check("glitch_idle", busy, 0);

        // Short EW request: minimum hold applies.
        pulse(1'b0, 1'b1, 10, 16, 1'b1, 1, 1'b0);

        // Simultaneous requests: NS wins, pulse tracks sync drop (30 + 2 - 6 = 26).
        pulse(1'b1, 1'b1, 30, 26, 1'b0, 2, 1'b0);

        // Stuck NS sensor: timeout, cooldown, re-arm, then released.
        @(negedge clock);
        e0     = cyc + 1;
        req_ns = 1'b1;
        push(e0 + 6, 255, 1'b0, 3, 1'b1);
        push(e0 + 274, 16, 1'b0, 4, 1'b1);
        while (cyc < e0 + 279) @(negedge clock);
        req_ns = 1'b0;
        wait_idle();
        check("fault_sticky", fault, 1);

        // Asynchronous reset while pre-empting.
        @(negedge clock);
        req_ns = 1'b1;
        b = 0;
        while (!emergency && b < 20) begin
            @(negedge clock);
            b++;
        end
        check("t5_reached_preempt", emergency, 1);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check("async_emergency", emergency, 0);
        check("async_busy", busy, 0);
        check("async_fault", fault, 0);
        check("async_count", preempt_count, 0);
        req_ns = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        seen_b = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (busy || emergency) seen_b = 1'b1;
        end
        check("post_reset_quiet", seen_b, 0);
        check("post_reset_count", preempt_count, 0);

        // Five complete pre-emptions; 2-bit instance saturates at 3.
        for (int i = 0; i < 5; i++) begin
            pulse(i[0] == 1'b0, i[0] == 1'b1, 10, 16, i[0], i + 1, 1'b0);
        end

        repeat (5) @(negedge clock);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
